// File: rtl/pattern_scan_pkg.sv
// Shared types and default constants for the serial pattern scan controller.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } scan_state_e;

    localparam int         PAT_W_DEF   = 4;
    localparam logic [3:0] PATTERN_DEF = 4'b1001;
    localparam int         CNT_W_DEF   = 8;

endpackage

// File: rtl/pattern_window_match.sv
// Sliding PAT_W-bit window over the serial stream; flags a match once the window is full.
module pattern_window_match #(
    parameter int PAT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match_next,
    output logic             match_pulse
);

    localparam int SEEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  window_next;
    logic [SEEN_W-1:0] bits_seen;

    assign window_next = {window[PAT_W-2:0], bit_in};

    // Qualify with bits_seen so a zero-filled window never matches a pattern like 0001.
    assign match_next = shift_en
                     && ((32'(bits_seen) + 32'd1) >= 32'(PAT_W))
                     && (window_next == pattern);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            window    <= '0;
            bits_seen <= '0;
        end else if (shift_en) begin
            window <= window_next;
            if (bits_seen != SEEN_W'(PAT_W)) begin
                bits_seen <= bits_seen + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= match_next;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: serializes words MSB-first, counts overlapping pattern matches per frame.
// Define PATTERN_SCAN_RUNTIME_PAT_EN to take the pattern from cfg_pattern at frame start.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int               CNT_W   = CNT_W_DEF
) (
`ifdef PATTERN_SCAN_RUNTIME_PAT_EN
    input  logic [PAT_W-1:0]  cfg_pattern,
`endif
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              bit_out,
    output logic              match_pulse,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [CNT_W-1:0]  done_count,
    output scan_state_e       state_dbg
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    scan_state_e       state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              last_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              match_next;
    logic              win_clear;
    logic [PAT_W-1:0]  pat_cur;

`ifdef PATTERN_SCAN_RUNTIME_PAT_EN
    logic [PAT_W-1:0] pat_reg;
    logic             frame_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            pat_reg      <= PATTERN;
            frame_active <= 1'b0;
        end else if (state == IDLE && in_valid && in_ready) begin
            if (!frame_active) begin
                pat_reg <= cfg_pattern;
            end
            frame_active <= 1'b1;
        end else if (done_valid && done_ready) begin
            frame_active <= 1'b0;
        end
    end

    assign pat_cur = pat_reg;
`else
    assign pat_cur = PATTERN;
`endif

    assign state_dbg  = state;
    assign win_clear  = done_valid && done_ready;
    assign count_next = (match_next && (count != '1)) ? count + 1'b1 : count;

    pattern_window_match #(.PAT_W(PAT_W)) u_window (
        .clock       (clock),
        .reset       (reset),
        .clear       (win_clear),
        .shift_en    (state == SHIFT),
        .bit_in      (bit_out),
        .pattern     (pat_cur),
        .match_next  (match_next),
        .match_pulse (match_pulse)
    );

    // bit_out is the bit being scanned this cycle; shreg holds the bits still to come.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            bit_out    <= 1'b0;
            done_valid <= 1'b0;
            done_count <= '0;
            count      <= '0;
            shreg      <= '0;
            idx        <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        bit_out  <= in_data[DATA_W-1];
                        shreg    <= {in_data[DATA_W-2:0], 1'b0};
                        last_q   <= in_last;
                        idx      <= IDX_W'(DATA_W - 1);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    count <= count_next;
                    if (idx == '0) begin
                        bit_out <= 1'b0;
                        if (last_q) begin
                            done_valid <= 1'b1;
                            done_count <= count_next;
                            state      <= REPORT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        idx     <= idx - 1'b1;
                        bit_out <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    end
                end
                REPORT: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        count      <= '0;
                        in_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
